// File: rtl/vit_pkg.sv
// Shared constants and helpers for the K=7 rate-1/2 hard-decision Viterbi decoder.
// Generators g0=133o, g1=171o; state s[5:0] with s[0] the newest input bit.
package vit_pkg;

  localparam int K = 7;
  localparam int NSTATES = 64;
  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;

  // Tap vector MSB is the newest bit (delay 0), LSB the bit leaving (x).
  function automatic logic [1:0] exp_pair(logic [5:0] ns, logic x);
    logic [6:0] r;
    r = {ns[0], ns[1], ns[2], ns[3], ns[4], ns[5], x};
    return {^(r & G0), ^(r & G1)};
  endfunction

  function automatic int unsigned pm_init(int pm_w);
    return 32'd1 << (pm_w - 2);
  endfunction

  function automatic logic [1:0] branch_metric(
    logic [1:0] e,
    logic       a,
    logic       b
  );
    return {1'b0, e[1] ^ a} + {1'b0, e[0] ^ b};
  endfunction

endpackage

// File: rtl/vit_acs.sv
// One add-compare-select lane: picks the cheaper predecessor (x=0 on ties)
// and shifts the decided bit into the chosen register-exchange survivor.
module vit_acs
  import vit_pkg::*;
#(
  parameter int   PM_W  = 7,
  parameter int   DEPTH = 36,
  parameter logic DBIT  = 1'b0
) (
  input  logic [PM_W-1:0]  pm0,
  input  logic [PM_W-1:0]  pm1,
  input  logic [1:0]       bm0,
  input  logic [1:0]       bm1,
  input  logic [DEPTH-2:0] sv0,
  input  logic [DEPTH-2:0] sv1,
  output logic [PM_W-1:0]  pm_o,
  output logic [DEPTH-2:0] sv_o,
  output logic             old_o
);

  logic [PM_W-1:0]  c0;
  logic [PM_W-1:0]  c1;
  logic [DEPTH-2:0] sel;
  logic             take1;

  always_comb begin
    c0    = pm0 + PM_W'(bm0);
    c1    = pm1 + PM_W'(bm1);
    take1 = c1 < c0;
    pm_o  = take1 ? c1 : c0;
    sel   = take1 ? sv1 : sv0;
    sv_o  = {sel[DEPTH-3:0], DBIT};
    old_o = sel[DEPTH-2];
  end

endmodule

// File: rtl/viterbi_dec.sv
// Register-exchange Viterbi decoder, 64 parallel ACS lanes, fixed survivor depth.
// Define VITDEC_BEST_STATE_EN to decode from the minimum-metric state instead of state 0.
module viterbi_dec
  import vit_pkg::*;
#(
  parameter int DEPTH = 36,
  parameter int PM_W  = 7
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEN,
  input  logic iClr,
  input  logic iDataA,
  input  logic iDataB,
  output logic oData,
  output logic oValid
);

  localparam int SW   = K - 1;
  localparam int HALF = NSTATES / 2;
  localparam int CW   = $clog2(DEPTH + 1);

  localparam logic [PM_W-1:0] PM_INIT = PM_W'(pm_init(PM_W));
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_OUT = CW'(DEPTH - 1);

  localparam logic [NSTATES-1:0][PM_W-1:0] PM_RST =
    {{(NSTATES-1){PM_INIT}}, {PM_W{1'b0}}};

  logic [NSTATES-1:0][PM_W-1:0] pm_q;
  logic [NSTATES-1:0][PM_W-1:0] pm_d;
  logic [NSTATES-1:0][PM_W-1:0] pm_n;

  // The oldest survivor bit is consumed straight into the output register,
  // so only DEPTH-1 bits per state need storing.
  logic [NSTATES-1:0][DEPTH-2:0] sv_q;
  logic [NSTATES-1:0][DEPTH-2:0] sv_d;
  logic [NSTATES-1:0][DEPTH-2:0] sv_n;
  logic [NSTATES-1:0]            old_n;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          data_q;
  logic          data_d;
  logic          valid_q;
  logic          valid_d;

  logic               norm;
  logic               out_bit;
  logic [SW-1:0]      best;
  logic [NSTATES-1:0] best_oh;

  genvar gs;
  generate
    for (gs = 0; gs < NSTATES; gs++) begin : g_acs
      localparam int         P0 = gs >> 1;
      localparam int         P1 = P0 + HALF;
      localparam logic [1:0] E0 = exp_pair(SW'(gs), 1'b0);
      localparam logic [1:0] E1 = exp_pair(SW'(gs), 1'b1);

      logic [1:0] bm0;
      logic [1:0] bm1;

      assign bm0 = branch_metric(E0, iDataA, iDataB);
      assign bm1 = branch_metric(E1, iDataA, iDataB);

      vit_acs #(
        .PM_W (PM_W),
        .DEPTH(DEPTH),
        .DBIT (1'(gs % 2))
      ) u_acs (
        .pm0  (pm_q[P0]),
        .pm1  (pm_q[P1]),
        .bm0  (bm0),
        .bm1  (bm1),
        .sv0  (sv_q[P0]),
        .sv1  (sv_q[P1]),
        .pm_o (pm_n[gs]),
        .sv_o (sv_n[gs]),
        .old_o(old_n[gs])
      );
    end
  endgenerate

  always_comb begin
    norm = 1'b1;
    for (int s = 0; s < NSTATES; s++) begin
      norm = norm & pm_n[s][PM_W-1];
    end
  end

`ifdef VITDEC_BEST_STATE_EN
  // Heap-ordered min tree: leaves 64..127 are states 0..63, the left
  // child always covers lower indices so it keeps ties.
  logic [2*NSTATES-1:2][PM_W-1:0] tm;
  logic [2*NSTATES-1:2][SW-1:0]   ti;

  always_comb begin
    tm = '0;
    ti = '0;
    for (int i = 0; i < NSTATES; i++) begin
      tm[NSTATES+i] = pm_n[i];
      ti[NSTATES+i] = SW'(i);
    end
    for (int n = NSTATES - 1; n >= 2; n--) begin
      if (tm[2*n+1] < tm[2*n]) begin
        tm[n] = tm[2*n+1];
        ti[n] = ti[2*n+1];
      end else begin
        tm[n] = tm[2*n];
        ti[n] = ti[2*n];
      end
    end
    best = (tm[3] < tm[2]) ? ti[3] : ti[2];
  end
`else
  assign best = '0;
`endif

  always_comb begin
    best_oh       = '0;
    best_oh[best] = 1'b1;
    out_bit       = |(old_n & best_oh);
  end

  always_comb begin
    pm_d    = pm_q;
    sv_d    = sv_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (iClr) begin
      pm_d   = PM_RST;
      sv_d   = '0;
      cnt_d  = '0;
      data_d = 1'b0;
    end else if (iEN) begin
      sv_d = sv_n;
      for (int s = 0; s < NSTATES; s++) begin
        pm_d[s] = pm_n[s];
        if (norm) pm_d[s][PM_W-1] = 1'b0;
      end
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      if (cnt_q >= CNT_OUT) begin
        valid_d = 1'b1;
        data_d  = out_bit;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      pm_q    <= PM_RST;
      sv_q    <= '0;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pm_q    <= pm_d;
      sv_q    <= sv_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;

endmodule
